// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three buses around the arbiter: the instruction-fetch request
// port (i_*), the data request port (d_*) and the downstream single memory
// port (mem_*).
//   slave  : the arbiter's view. Takes requests and memory responses, and
//            drives read data, response pulses and the downstream strobes.
//   master : the environment's view (datapath and memory model together).
// ADDR_WIDTH sets every address bus. DATA_WIDTH sets every data bus, and the
// byte-mask width is DATA_WIDTH/8.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction side
    logic                      i_req;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic [DATA_WIDTH-1:0]     i_rdata;
    logic                      i_resp;
    // Data side
    logic                      d_read;
    logic                      d_write;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH/8-1:0]   d_wmask;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_resp;
    // Downstream memory port
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_read;
    logic                      mem_write;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_resp;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wmask, d_wdata,
        output d_rdata, d_resp,
        output mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wmask, d_wdata,
        input  d_rdata, d_resp,
        input  mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the data port. It handles one transaction at a time. Each
// granted request is latched, and its latched copy drives mem_* until
// mem_resp. The owner then gets a one-cycle response pulse together with the
// registered read data.
//
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - synchronous reset, active low
//   bus  - mem_port_arbiter_if.slave (i_*, d_*, mem_* buses)
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, a conflict in IDLE is resolved by a
//                        1-bit round-robin pointer. The pointer starts out
//                        favouring I. When undefined, D always wins a
//                        conflict.
//
// Every output is driven from a register or decoded from the state register
// alone. No input reaches an output combinationally.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic                    grant_i;
    logic                    grant_d;
    logic                    d_pending;

    // Latched transaction
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [MASK_WIDTH-1:0]   wmask_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    write_reg;

    // Upstream response registers
    logic [DATA_WIDTH-1:0]   i_rdata_reg;
    logic [DATA_WIDTH-1:0]   d_rdata_reg;
    logic                    i_resp_reg;
    logic                    d_resp_reg;

    // Strobes decoded from state_reg
    logic                    mem_read_dec;
    logic                    mem_write_dec;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when D should win the next conflict, i.e. I was granted last.
    logic                    favour_d_reg;
`endif

    // A simultaneous read and write on the D side is treated as a write. That
    // only affects the latched op; either one makes D pending.
    assign d_pending = bus.d_read | bus.d_write;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, including the arbitration decision
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state_reg)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (d_pending && (!bus.i_req || favour_d_reg)) begin
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end
`else
                if (d_pending) begin
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end
`endif
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_i) begin
                    state_next = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                // The response pulse goes out in the cycle spent in IDLE,
                // so a new grant can follow one cycle after mem_resp.
                if (bus.mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. The strobes depend on state_reg and latched op only.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read_dec  = 1'b0;
        mem_write_dec = 1'b0;
        case (state_reg)
            I_BUSY: mem_read_dec = 1'b1;
            D_BUSY: begin
                mem_read_dec  = ~write_reg;
                mem_write_dec = write_reg;
            end
            default: begin
                mem_read_dec  = 1'b0;
                mem_write_dec = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction latches, read-data capture and response pulses.
    // mem_resp in IDLE matches none of the conditions below, so a stray
    // response is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg    <= '0;
            wmask_reg   <= '0;
            wdata_reg   <= '0;
            write_reg   <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            i_resp_reg  <= 1'b0;
            d_resp_reg  <= 1'b0;
        end else begin
            i_resp_reg <= (state_reg == I_BUSY) && bus.mem_resp;
            d_resp_reg <= (state_reg == D_BUSY) && bus.mem_resp;

            if ((state_reg == I_BUSY) && bus.mem_resp) begin
                i_rdata_reg <= bus.mem_rdata;
            end
            // A completed write leaves d_rdata as it was.
            if ((state_reg == D_BUSY) && bus.mem_resp && !write_reg) begin
                d_rdata_reg <= bus.mem_rdata;
            end

            if (grant_d) begin
                addr_reg  <= bus.d_addr;
                wmask_reg <= bus.d_wmask;
                wdata_reg <= bus.d_wdata;
                write_reg <= bus.d_write;
            end else if (grant_i) begin
                addr_reg  <= bus.i_addr;
                wmask_reg <= '0;
                write_reg <= 1'b0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            favour_d_reg <= 1'b0;
        end else if (grant_d) begin
            favour_d_reg <= 1'b0;
        end else if (grant_i) begin
            favour_d_reg <= 1'b1;
        end
    end
`endif

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wmask = wmask_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_read  = mem_read_dec;
    assign bus.mem_write = mem_write_dec;
    assign bus.i_rdata   = i_rdata_reg;
    assign bus.i_resp    = i_resp_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.d_resp    = d_resp_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Exercises mem_port_arbiter with the directed scenarios first and then with
// randomized requesters and a random-latency memory. A transaction-level
// reference model predicts the expected outputs. It tracks who owns the
// memory port, what that owner asked for, and which response is due next.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = instruction side, 2 = data side
    int          owner = 0;
    logic        t_write;
    logic [31:0] t_addr;
    logic [3:0]  t_wmask;
    logic [31:0] t_wdata;
    logic        e_i_resp, e_d_resp;
    logic [31:0] e_i_rdata, e_d_rdata;
    bit          last_was_i;   // last granted side was I
    bit          was_reset;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the effect of the coming rising edge to the model, using the
    // inputs the bench is currently driving.
    task automatic model_edge();
        int  prev;
        bit  want_i, want_d, pick_d;
        if (!rst) begin
            owner = 0; e_i_resp = 0; e_d_resp = 0;
            e_i_rdata = 0; e_d_rdata = 0; last_was_i = 0; was_reset = 1;
            return;
        end
        was_reset = 0;
        prev = owner;
        e_i_resp = (prev == 1) && bus.mem_resp;
        e_d_resp = (prev == 2) && bus.mem_resp;
        if (prev == 1 && bus.mem_resp) begin
            e_i_rdata = bus.mem_rdata;
            owner = 0;
        end
        if (prev == 2 && bus.mem_resp) begin
            if (!t_write) e_d_rdata = bus.mem_rdata;
            owner = 0;
        end
        if (prev == 0) begin
            want_i = bus.i_req;
            want_d = bus.d_read || bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = want_d && (!want_i || last_was_i);
`else
            pick_d = want_d;
`endif
            if (pick_d) begin
                owner = 2; t_write = bus.d_write; t_addr = bus.d_addr;
                t_wmask = bus.d_wmask; t_wdata = bus.d_wdata; last_was_i = 0;
            end else if (want_i) begin
                owner = 1; t_write = 0; t_addr = bus.i_addr; last_was_i = 1;
            end
        end
    endtask

    task automatic model_check();
        chk("mem_read",  32'(bus.mem_read),  32'(owner == 1 || (owner == 2 && !t_write)));
        chk("mem_write", 32'(bus.mem_write), 32'(owner == 2 && t_write));
        chk("i_resp",    32'(bus.i_resp),    32'(e_i_resp));
        chk("d_resp",    32'(bus.d_resp),    32'(e_d_resp));
        chk("i_rdata",   bus.i_rdata,        e_i_rdata);
        chk("d_rdata",   bus.d_rdata,        e_d_rdata);
        if (owner != 0) chk("mem_addr", bus.mem_addr, t_addr);
        if (owner == 2 && t_write) begin
            chk("mem_wmask", 32'(bus.mem_wmask), 32'(t_wmask));
            chk("mem_wdata", bus.mem_wdata, t_wdata);
        end
        if (was_reset) begin
            chk("rst_mem_addr",  bus.mem_addr,         32'h0);
            chk("rst_mem_wmask", 32'(bus.mem_wmask),   32'h0);
            chk("rst_mem_wdata", bus.mem_wdata,        32'h0);
        end
    endtask

    // One clock: model the edge, let it happen, check at the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = 0;
        bus.d_wmask = 0; bus.d_wdata = 0;
        bus.mem_resp = 0; bus.mem_rdata = 0;
    endtask

    initial begin
        int  ngr;
        bit  i_act, d_act;
        int  k;
        bit  exp_d;

        rst = 0;
        idle_inputs();

        // ---- reset ----
        cycle();
        cycle();
        chk("reset_i_rdata", bus.i_rdata, 32'h0);
        chk("reset_strobes", 32'({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}), 32'h0);
        rst = 1;
        $display("txn reset done");

        // ---- single fetch, memory answers in the third strobe cycle ----
        bus.i_req = 1; bus.i_addr = 32'h0000_0040;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("fetch_strobe", 32'(bus.mem_read), 32'h1);
            chk("fetch_addr", bus.mem_addr, 32'h40);
        end
        bus.mem_resp = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("fetch_resp", 32'(bus.i_resp), 32'h1);
        chk("fetch_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        chk("fetch_strobe_off", 32'(bus.mem_read), 32'h0);
        bus.i_req = 0; bus.mem_resp = 0;
        cycle();
        chk("fetch_resp_once", 32'(bus.i_resp), 32'h0);
        chk("fetch_rdata_held", bus.i_rdata, 32'hDEAD_BEEF);
        $display("txn fetch addr=%h rdata=%h", 32'h40, bus.i_rdata);

        // ---- data write ----
        bus.d_write = 1; bus.d_addr = 32'h100; bus.d_wmask = 4'h3; bus.d_wdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("write_strobe", 32'(bus.mem_write), 32'h1);
            chk("write_wmask", 32'(bus.mem_wmask), 32'h3);
            chk("write_wdata", bus.mem_wdata, 32'h1234_5678);
        end
        bus.mem_resp = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        cycle();
        chk("write_resp", 32'(bus.d_resp), 32'h1);
        chk("write_rdata_kept", bus.d_rdata, 32'h0);
        bus.d_write = 0; bus.mem_resp = 0;
        cycle();
        $display("txn write addr=%h wdata=%h", 32'h100, 32'h1234_5678);

        // ---- conflict: both sides held, memory answers immediately ----
        bus.i_req = 1; bus.i_addr = 32'hA0;
        bus.d_read = 1; bus.d_addr = 32'hB0;
        bus.mem_resp = 1;
        ngr = 0;
        for (int c = 0; c < 40 && ngr < 6; c++) begin
            bus.mem_rdata = $urandom;
            cycle();
            if (bus.mem_read === 1'b1) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_d = (ngr % 2) == 1;
`else
                exp_d = 1;
`endif
                chk("conflict_order", 32'(bus.mem_addr == 32'hB0), 32'(exp_d));
                $display("txn conflict grant %0d to %s", ngr, (bus.mem_addr == 32'hB0) ? "D" : "I");
                ngr++;
            end
        end
        chk("conflict_grants", 32'(ngr), 32'd6);
        bus.i_req = 0; bus.d_read = 0;
        cycle();
        bus.mem_resp = 0;
        cycle();

        // ---- input churn after grant ----
        bus.d_read = 1; bus.d_addr = 32'h200;
        cycle();
        bus.d_addr = 32'h300;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("churn_addr", bus.mem_addr, 32'h200);
        end
        bus.mem_resp = 1; bus.mem_rdata = 32'h55AA_33CC;
        cycle();
        chk("churn_resp", 32'(bus.d_resp), 32'h1);
        chk("churn_rdata", bus.d_rdata, 32'h55AA_33CC);
        bus.d_read = 0; bus.mem_resp = 0;
        cycle();
        $display("txn churn addr=%h rdata=%h", 32'h200, bus.d_rdata);

        // ---- stray mem_resp while idle ----
        bus.mem_resp = 1; bus.mem_rdata = 32'h0BAD_0BAD;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("stray_no_resp", 32'({bus.i_resp, bus.d_resp}), 32'h0);
            chk("stray_idle", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        end
        bus.mem_resp = 0;
        $display("txn stray response ignored");

        // ---- reset in the middle of a data write ----
        bus.d_write = 1; bus.d_addr = 32'h400; bus.d_wmask = 4'hF; bus.d_wdata = 32'hCAFE_F00D;
        cycle();
        chk("rstmid_busy", 32'(bus.mem_write), 32'h1);
        rst = 0; bus.d_write = 0; bus.i_req = 1; bus.i_addr = 32'h80;
        cycle();
        chk("rstmid_no_resp", 32'(bus.d_resp), 32'h0);
        chk("rstmid_outputs", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk("rstmid_d_rdata", bus.d_rdata, 32'h0);
        chk("rstmid_i_rdata", bus.i_rdata, 32'h0);
        rst = 1;
        cycle();
        chk("rstmid_regrant", 32'(bus.mem_read), 32'h1);
        chk("rstmid_addr", bus.mem_addr, 32'h80);
        bus.mem_resp = 1; bus.mem_rdata = 32'h7777_0001;
        cycle();
        chk("rstmid_i_resp", 32'(bus.i_resp), 32'h1);
        bus.i_req = 0; bus.mem_resp = 0;
        cycle();
        $display("txn reset mid-op, then fetch rdata=%h", bus.i_rdata);

        // ---- randomized traffic ----
        i_act = 0; d_act = 0;
        for (int c = 0; c < 1500; c++) begin
            if (i_act && e_i_resp) begin
                i_act = ($urandom_range(0, 1) == 1);
                if (i_act) bus.i_addr = $urandom;
            end else if (!i_act) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_act = 1; bus.i_addr = $urandom;
                end
            end else if (owner == 1 && $urandom_range(0, 1) == 0) begin
                bus.i_addr = $urandom;
            end
            bus.i_req = i_act;

            if ((d_act && e_d_resp) || !d_act) begin
                d_act = (d_act && e_d_resp) ? ($urandom_range(0, 1) == 1)
                                            : ($urandom_range(0, 2) == 0);
                if (d_act) begin
                    k = $urandom_range(0, 3);
                    bus.d_read  = (k == 0) || (k == 2);
                    bus.d_write = (k != 0);
                    bus.d_addr  = $urandom;
                    bus.d_wmask = (k == 3) ? 4'h0 : 4'($urandom_range(0, 15));
                    bus.d_wdata = $urandom;
                end else begin
                    bus.d_read = 0; bus.d_write = 0;
                end
            end else if (owner == 2 && $urandom_range(0, 1) == 0) begin
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end

            bus.mem_rdata = $urandom;
            bus.mem_resp  = (owner != 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 249) != 0);
            if (!rst) begin
                i_act = 0; d_act = 0;
                bus.i_req = 0; bus.d_read = 0; bus.d_write = 0;
            end
            cycle();
            if (bus.i_resp === 1'b1 || bus.d_resp === 1'b1)
                $display("txn random cycle %0d i_resp=%0b d_resp=%0b i_rdata=%h d_rdata=%h",
                         c, bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
